// File: rtl/beep_seq.sv
// beep_seq: counted, gated, abortable piezo tone-burst sequencer.
// Latency: start sampled at edge k -> busy high after edge k; first buz rise TONE_HALF cycles later.
// Backpressure: none; start is ignored while a sequence runs, abort cancels at the next edge.
module beep_seq #(
  parameter int TONE_HALF = 20000,
  parameter int ON_CYC    = 5000000,
  parameter int OFF_CYC   = 5000000,
  parameter int DUR_W     = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] beep_num,
  input  logic       long_mode,
  input  logic       abort,
  output logic       buz,
  output logic       busy,
  output logic       done
);

  localparam int TONE_W = (2 * TONE_HALF > 2) ? $clog2(2 * TONE_HALF) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [1:0]          rst_sync;
  logic                rst_int_n;
  logic [DUR_W-1:0]    dur;
  logic [DUR_W-1:0]    dur_nxt;
  logic [TONE_W-1:0]   tone;
  logic [TONE_W-1:0]   tone_nxt;
  logic [3:0]          rem;
  logic [3:0]          rem_nxt;
  logic                long_q;
  logic                long_nxt;
  logic                on_last;
  logic                off_last;
  logic                tone_wrap;
  logic                buz_nxt;
  logic                busy_nxt;
  logic                done_nxt;

  // Reset asserts immediately but releases two clock edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  // Burst length doubles in long mode; the last cycle of each phase ends it.
  assign on_last   = (dur == (long_q ? DUR_W'(2 * ON_CYC - 1) : DUR_W'(ON_CYC - 1)));
  assign off_last  = (dur == DUR_W'(OFF_CYC - 1));
  assign tone_wrap = (tone == TONE_W'(2 * TONE_HALF - 1));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state  <= S_IDLE;
      dur    <= '0;
      tone   <= '0;
      rem    <= '0;
      long_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      dur    <= dur_nxt;
      tone   <= tone_nxt;
      rem    <= rem_nxt;
      long_q <= long_nxt;
    end
  end

  // Next state and counter updates; abort always beats start and burst end.
  always_comb begin
    state_nxt = state;
    dur_nxt   = dur;
    tone_nxt  = tone;
    rem_nxt   = rem;
    long_nxt  = long_q;
    case (state)
      S_IDLE: begin
        if (start && !abort && (beep_num != 4'd0)) begin
          state_nxt = S_ON;
          rem_nxt   = beep_num;
          long_nxt  = long_mode;
          dur_nxt   = '0;
          tone_nxt  = '0;
        end
      end
      S_ON: begin
        if (abort || (on_last && (rem == 4'd1))) begin
          state_nxt = S_IDLE;
          dur_nxt   = '0;
          tone_nxt  = '0;
          rem_nxt   = '0;
          long_nxt  = 1'b0;
        end else if (on_last) begin
          state_nxt = S_OFF;
          rem_nxt   = rem - 4'd1;
          dur_nxt   = '0;
          tone_nxt  = '0;
        end else begin
          dur_nxt   = dur + DUR_W'(1);
          tone_nxt  = tone_wrap ? '0 : tone + TONE_W'(1);
        end
      end
      S_OFF: begin
        if (abort) begin
          state_nxt = S_IDLE;
          dur_nxt   = '0;
          tone_nxt  = '0;
          rem_nxt   = '0;
          long_nxt  = 1'b0;
        end else if (off_last) begin
          state_nxt = S_ON;
          dur_nxt   = '0;
          tone_nxt  = '0;
        end else begin
          dur_nxt   = dur + DUR_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        dur_nxt   = '0;
        tone_nxt  = '0;
        rem_nxt   = '0;
        long_nxt  = 1'b0;
      end
    endcase
  end

  // Output decode from the upcoming state so the outputs can be registered without lag.
  always_comb begin
    buz_nxt  = (state_nxt == S_ON) && (tone_nxt >= TONE_W'(TONE_HALF));
    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = 1'b0;
    if ((state == S_IDLE) && start && !abort && (beep_num == 4'd0)) done_nxt = 1'b1;
    if ((state == S_ON) && !abort && on_last && (rem == 4'd1))      done_nxt = 1'b1;
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      buz  <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      buz  <= buz_nxt;
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_beep_seq.sv
// tb_beep_seq: directed scenarios plus random traffic checked against a cycle-index model.
// Model: a running sequence is just (N, long, cycle index c); outputs follow from arithmetic on c.
// Inputs are driven at the falling edge, outputs sampled 1 ns after the rising edge.
`timescale 1ns/1ps
module tb_beep_seq;

  localparam int TH  = 4;
  localparam int ON  = 20;
  localparam int OFF = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] beep_num;
  logic       long_mode;
  logic       abort;
  logic       buz;
  logic       busy;
  logic       done;

  int n_chk  = 0;
  int n_pass = 0;

  // model state
  bit m_act = 0;
  int m_c   = 0;
  int m_n   = 0;
  bit m_long = 0;
  bit e_buz, e_busy, e_done;

  // scenario statistics
  int busy_cnt, rise_cnt, done_cnt;
  bit prev_buz = 0;

  beep_seq #(
    .TONE_HALF(TH),
    .ON_CYC   (ON),
    .OFF_CYC  (OFF),
    .DUR_W    (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .beep_num (beep_num),
    .long_mode(long_mode),
    .abort    (abort),
    .buz      (buz),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic bit buz_at(input int c, input bit lng);
    int onl, pos;
    onl = lng ? 2 * ON : ON;
    pos = c % (onl + OFF);
    return (pos < onl) && ((pos % (2 * TH)) >= TH);
  endfunction

  function automatic int seq_len(input int n, input bit lng);
    int onl;
    onl = lng ? 2 * ON : ON;
    return n * onl + (n - 1) * OFF;
  endfunction

  // Advance the model across one rising edge given the inputs sampled there.
  task automatic model_step(input bit st, input int num, input bit lng, input bit ab);
    e_done = 0;
    if (m_act) begin
      if (ab) m_act = 0;
      else begin
        m_c++;
        if (m_c == seq_len(m_n, m_long)) begin
          m_act  = 0;
          e_done = 1;
        end
      end
    end else if (st && !ab) begin
      if (num != 0) begin
        m_act  = 1;
        m_c    = 0;
        m_n    = num;
        m_long = lng;
      end else begin
        e_done = 1;
      end
    end
    e_busy = m_act;
    e_buz  = m_act && buz_at(m_c, m_long);
  endtask

  task automatic clr_stats();
    busy_cnt = 0;
    rise_cnt = 0;
    done_cnt = 0;
  endtask

  // One clock cycle: drive, clock, model, compare.
  task automatic cyc(input bit st, input int num, input bit lng, input bit ab);
    @(negedge clk);
    start     = st;
    beep_num  = 4'(num);
    long_mode = lng;
    abort     = ab;
    @(posedge clk);
    model_step(st, num, lng, ab);
    #1;
    chk("buz", int'(buz), int'(e_buz));
    chk("busy", int'(busy), int'(e_busy));
    chk("done", int'(done), int'(e_done));
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (buz && !prev_buz) rise_cnt++;
    prev_buz = buz;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  initial begin
    bit gap_buz;
    rst_n = 1'b0; start = 1'b0; beep_num = 4'd0; long_mode = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_buz", int'(buz), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    // two short bursts
    clr_stats();
    cyc(1, 2, 0, 0);
    gap_buz = 0;
    for (int j = 1; j <= 50; j++) begin
      cyc(0, 0, 0, 0);
      if (j >= 20 && j <= 29 && buz) gap_buz = 1;
    end
    chk("s1_busy_cycles", busy_cnt, 50);
    chk("s1_rises", rise_cnt, 4);
    chk("s1_gap_silent", int'(gap_buz), 0);
    chk("s1_done_cnt", done_cnt, 1);
    idle(3);

    // one long burst
    clr_stats();
    cyc(1, 1, 1, 0);
    for (int j = 1; j <= 40; j++) cyc(0, 0, 0, 0);
    chk("long_busy_cycles", busy_cnt, 40);
    chk("long_rises", rise_cnt, 5);
    chk("long_done_cnt", done_cnt, 1);
    idle(2);

    // zero beeps: immediate done only
    cyc(1, 0, 0, 0);
    chk("zero_done", int'(done), 1);
    chk("zero_busy", int'(busy), 0);
    cyc(0, 0, 0, 0);
    chk("zero_done_drop", int'(done), 0);

    // abort together with start in IDLE drops the request
    cyc(1, 2, 0, 1);
    chk("abort_start_busy", int'(busy), 0);
    idle(2);

    // abort during the first gap, then a fresh full run
    clr_stats();
    cyc(1, 3, 0, 0);
    for (int j = 1; j <= 25; j++) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_buz", int'(buz), 0);
    cyc(0, 0, 0, 0);
    chk("abort_no_done", done_cnt, 0);
    clr_stats();
    cyc(1, 3, 0, 0);
    for (int j = 1; j <= 80; j++) cyc(0, 0, 0, 0);
    chk("fresh_busy_cycles", busy_cnt, 80);
    chk("fresh_done_cnt", done_cnt, 1);
    idle(2);

    // starts during a run are ignored; a start in the done cycle is accepted
    clr_stats();
    cyc(1, 2, 0, 0);
    for (int j = 1; j <= 50; j++) cyc((j == 5 || j == 35), 7, 1, 0);
    chk("ign_busy_cycles", busy_cnt, 50);
    chk("ign_done_cnt", done_cnt, 1);
    cyc(1, 1, 0, 0);
    chk("done_cycle_restart", int'(busy), 1);
    idle(25);

    // asynchronous reset in the middle of a burst, while buz is high
    cyc(1, 2, 0, 0);
    idle(5);
    chk("pre_rst_buz", int'(buz), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_buz", int'(buz), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    m_act = 0;
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    cyc(1, 1, 0, 0);
    chk("post_rst_start", int'(busy), 1);
    idle(25);

    // random traffic
    for (int i = 0; i < 15000; i++) begin
      bit st, lng, ab;
      int num;
      st  = ($urandom_range(0, 19) == 0);
      num = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
      lng = 1'($urandom_range(0, 1));
      ab  = ($urandom_range(0, 399) == 0);
      cyc(st, num, lng, ab);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
